game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game-phase controller. Sequences attract, start countdown, play, hit pause, wave clear and game over.
- Gates per-frame updates of the player, laser and invaders blocks through run_en.
- Issues restart pulses to the sprite blocks and score_logic.
- Sits beside score_logic on the system clk and consumes the frame strobe, debounced buttons, lives and the invader bitmap.

Parameters:
- START_FRAMES, 120, frames spent in START before play begins.
- HIT_FRAMES, 90, frames of freeze after the player is hit.
- CLEAR_FRAMES, 120, frames of freeze after a wave is cleared.
- OVER_FRAMES, 180, minimum frames in OVER before start is accepted.
- INVASION_Y, 10'd400, invader-block bottom row that ends the game.
- BLOCK_H, 10'd80, height of the invader formation in pixels.
- MAX_WAVE, 15, saturation value of the wave counter.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- arst  in  1  debounced reset-button pulse; synchronous game restart.
- frame  in  1  one-clk pulse per video frame, clk domain.
- start  in  1  debounced shoot button, one-clk pulse.
- player_collision  in  1  one-clk pulse, player hit.
- lives  in  2  current lives from score_logic.
- invaders  in  55  alive bitmap, 1 = alive.
- invaders_y  in  10  top row of the invader formation.
- state  out  3  0 ATTRACT, 1 START, 2 PLAY, 3 HIT, 4 CLEAR, 5 OVER.
- run_en  out  1  high only in PLAY; gates player, laser and invader motion.
- wave_rst  out  1  one-clk pulse: re-initialise invaders and laser.
- game_rst  out  1  one-clk pulse: re-initialise score and lives.
- wave  out  4  current wave number, 1-based.
- banner  out  1  high in ATTRACT, START, CLEAR and OVER for the overlay.

Behaviour:
- All outputs are registered; every state change takes effect on the clk edge after the triggering input.
- Reset (rst or arst): state=ATTRACT, run_en=0, wave_rst=0, game_rst=0, wave=1, banner=1, frame counter=0. rst has priority over arst. arst acts the same as rst but is a plain logic input.
- The frame counter is 8 bits. It clears on every state entry and increments on frame pulses while the state is START, HIT, CLEAR or OVER. It saturates at 255.
- invaded = |invaders && (invaders_y + BLOCK_H >= INVASION_Y). The addition is done at 11 bits so it cannot wrap.
- cleared = (invaders == 0).
- ATTRACT -> START on start. In the same edge, game_rst=1 and wave_rst=1 for one clk, and wave=1.
- START -> PLAY when the counter reaches START_FRAMES-1 and a frame pulse arrives.
- PLAY, per clk, in priority order:
  - invaded -> OVER.
  - player_collision -> HIT.
  - cleared -> CLEAR.
  - otherwise stay in PLAY.
  - run_en drops on the same edge as the state change.
- HIT -> after HIT_FRAMES frames: PLAY if lives != 0, else OVER.
  - lives is sampled at exit, because score_logic decrements lives after the collision.
- CLEAR -> START after CLEAR_FRAMES frames.
  - wave increments, saturating at MAX_WAVE.
  - wave_rst pulses once on that edge; game_rst does not.
- OVER: start is ignored until the counter reaches OVER_FRAMES-1. After that, start -> START with game_rst and wave_rst pulsed and wave=1.
- start is ignored in START, PLAY, HIT and CLEAR.
- player_collision is ignored outside PLAY.
- Simultaneous frame and start in OVER exactly at the threshold: the threshold test uses the pre-increment counter value. start is accepted only if the counter already equals OVER_FRAMES-1.
- wave_rst and game_rst are never high for two consecutive clks.
- Undefined state encodings (6, 7) return to ATTRACT on the next clk.

Decomposition:
- Shared constants package, extending util/constants.v: state encodings ST_ATTRACT through ST_OVER, the default frame counts, INVASION_Y and BLOCK_H.
- One natural sub-module: frame_timer. It is an 8-bit clear-on-load, frame-gated, saturating counter with a done compare, instantiated once. The FSM and output registers stay in game_sequencer.

Test Plan:
- Reset: rst for 2 clks -> state=0, run_en=0, wave=1, banner=1, both pulses 0. Then start -> state=1 next clk, with game_rst and wave_rst each high for exactly 1 clk.
- Start delay: from START, issue 120 frame pulses with gaps -> state=2 and run_en=1 exactly on the clk after the 120th pulse. Nothing changes after 119 pulses.
- Hit with lives=2: player_collision in PLAY -> state=3, run_en=0. After 90 frames -> state=2. Repeat with lives=0 at exit -> state=5.
- Wave clear: invaders=0 in PLAY -> state=4. After 120 frames -> state=1, wave=2, one wave_rst pulse, no game_rst. With wave=15 and another clear -> wave stays 15.
- Priority: same clk with player_collision=1, invaders=1 and invaders_y=330 (330+80 >= 400) -> state=5, not 3.
- Game over lockout: start at frame 100 of OVER -> ignored. start after 180 frames -> state=1, wave=1, game_rst pulse. arst mid-PLAY -> state=0 next clk.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared game-phase encodings and default timing/geometry constants
// for the game sequencer and its frame timer.
package game_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_ATTRACT = 3'd0,
      ST_START   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_HIT     = 3'd3,
      ST_CLEAR   = 3'd4,
      ST_OVER    = 3'd5
   } state_t;

   localparam int         TIMER_W        = 8;
   localparam int         START_FRAMES_D = 120;
   localparam int         HIT_FRAMES_D   = 90;
   localparam int         CLEAR_FRAMES_D = 120;
   localparam int         OVER_FRAMES_D  = 180;
   localparam logic [9:0] INVASION_Y_D   = 10'd400;
   localparam logic [9:0] BLOCK_H_D      = 10'd80;
   localparam int         MAX_WAVE_D     = 15;

   // Phases that show the text overlay.
   function automatic logic is_banner(input state_t s);
      return (s == ST_ATTRACT) || (s == ST_START) || (s == ST_CLEAR) || (s == ST_OVER);
   endfunction

   // Phases in which the frame counter advances.
   function automatic logic is_timed(input state_t s);
      return (s == ST_START) || (s == ST_HIT) || (s == ST_CLEAR) || (s == ST_OVER);
   endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame-gated saturating counter, cleared on load, with a
// "reached limit" compare on the current (pre-increment) count.
module frame_timer
   import game_sequencer_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         count_en,
   input  logic         frame,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         count_reg <= '0;
      end else if (count_en && frame && (count_reg != '1)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign done = (count_reg >= limit);

endmodule

// File: rtl/game_sequencer.sv
// Game-phase controller: attract, start countdown, play, hit freeze,
// wave clear and game over, with registered run enable and restart pulses.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int         START_FRAMES = START_FRAMES_D,
   parameter int         HIT_FRAMES   = HIT_FRAMES_D,
   parameter int         CLEAR_FRAMES = CLEAR_FRAMES_D,
   parameter int         OVER_FRAMES  = OVER_FRAMES_D,
   parameter logic [9:0] INVASION_Y   = INVASION_Y_D,
   parameter logic [9:0] BLOCK_H      = BLOCK_H_D,
   parameter int         MAX_WAVE     = MAX_WAVE_D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arst,
   input  logic        frame,
   input  logic        start,
   input  logic        player_collision,
   input  logic [1:0]  lives,
   input  logic [54:0] invaders,
   input  logic [9:0]  invaders_y,
   output logic [2:0]  state,
   output logic        run_en,
   output logic        wave_rst,
   output logic        game_rst,
   output logic [3:0]  wave,
   output logic        banner
);

   state_t       state_reg, state_next;
   logic         run_en_reg, run_en_next;
   logic         wave_rst_reg, wave_rst_next;
   logic         game_rst_reg, game_rst_next;
   logic         banner_reg, banner_next;
   logic [3:0]   wave_reg, wave_next;

   logic         restart;
   logic [10:0]  block_bottom;
   logic         invaded;
   logic         cleared;
   logic [TIMER_W-1:0] timer_limit;
   logic         timer_done;
   logic         frame_done;
   logic         new_game;
   logic         next_wave;

   assign restart      = rst || arst;
   // Widened so the bottom-row sum cannot wrap near the screen edge.
   assign block_bottom = {1'b0, invaders_y} + {1'b0, BLOCK_H};
   assign invaded      = (|invaders) && (block_bottom >= {1'b0, INVASION_Y});
   assign cleared      = (invaders == '0);
   assign frame_done   = timer_done && frame;

   always_comb begin
      timer_limit = '1;
      case (state_reg)
         ST_START: timer_limit = TIMER_W'(START_FRAMES - 1);
         ST_HIT:   timer_limit = TIMER_W'(HIT_FRAMES - 1);
         ST_CLEAR: timer_limit = TIMER_W'(CLEAR_FRAMES - 1);
         ST_OVER:  timer_limit = TIMER_W'(OVER_FRAMES - 1);
         default:  timer_limit = '1;
      endcase
   end

   frame_timer #(.W(TIMER_W)) u_frame_timer (
      .clk      (clk),
      .rst      (restart),
      .load     (state_next != state_reg),
      .count_en (is_timed(state_reg)),
      .frame    (frame),
      .limit    (timer_limit),
      .done     (timer_done)
   );

   always_ff @(posedge clk) begin
      if (restart) begin
         state_reg    <= ST_ATTRACT;
         run_en_reg   <= 1'b0;
         wave_rst_reg <= 1'b0;
         game_rst_reg <= 1'b0;
         banner_reg   <= 1'b1;
         wave_reg     <= 4'd1;
      end else begin
         state_reg    <= state_next;
         run_en_reg   <= run_en_next;
         wave_rst_reg <= wave_rst_next;
         game_rst_reg <= game_rst_next;
         banner_reg   <= banner_next;
         wave_reg     <= wave_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_ATTRACT: if (start) state_next = ST_START;
         ST_START:   if (frame_done) state_next = ST_PLAY;
         ST_PLAY: begin
            if (invaded)               state_next = ST_OVER;
            else if (player_collision) state_next = ST_HIT;
            else if (cleared)          state_next = ST_CLEAR;
         end
         // Lives are read at exit because the score block decrements after the hit.
         ST_HIT:     if (frame_done) state_next = (lives != 2'd0) ? ST_PLAY : ST_OVER;
         ST_CLEAR:   if (frame_done) state_next = ST_START;
         ST_OVER:    if (start && timer_done) state_next = ST_START;
         default:    state_next = ST_ATTRACT;
      endcase
   end

   always_comb begin
      new_game      = ((state_reg == ST_ATTRACT) || (state_reg == ST_OVER)) &&
                      (state_next == ST_START);
      next_wave     = (state_reg == ST_CLEAR) && (state_next == ST_START);
      run_en_next   = (state_next == ST_PLAY);
      banner_next   = is_banner(state_next);
      game_rst_next = new_game;
      wave_rst_next = new_game || next_wave;
      wave_next     = wave_reg;
      if (new_game) begin
         wave_next = 4'd1;
      end else if (next_wave && (wave_reg < 4'(MAX_WAVE))) begin
         wave_next = wave_reg + 4'd1;
      end
   end

   assign state    = state_reg;
   assign run_en   = run_en_reg;
   assign wave_rst = wave_rst_reg;
   assign game_rst = game_rst_reg;
   assign banner   = banner_reg;
   assign wave     = wave_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: single-clock vector table plus
// hand-written multi-frame sequences for timers, lockout and wave saturation.
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        rst, arst, frame, start, player_collision;
   logic [1:0]  lives;
   logic [54:0] invaders;
   logic [9:0]  invaders_y;
   logic [2:0]  state;
   logic        run_en, wave_rst, game_rst, banner;
   logic [3:0]  wave;

   int checks = 0;
   int errors = 0;

   localparam logic [54:0] ALL = {55{1'b1}};

   typedef struct {
      logic        st, fr, pc, ar;
      logic [1:0]  lv;
      logic [54:0] inv;
      logic [9:0]  inv_y;
      logic [2:0]  e_state;
      logic        e_run, e_wrst, e_grst;
      logic [3:0]  e_wave;
      logic        e_banner;
   } vec_t;

   vec_t vecs[13];

   game_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .arst             (arst),
      .frame            (frame),
      .start            (start),
      .player_collision (player_collision),
      .lives            (lives),
      .invaders         (invaders),
      .invaders_y       (invaders_y),
      .state            (state),
      .run_en           (run_en),
      .wave_rst         (wave_rst),
      .game_rst         (game_rst),
      .wave             (wave),
      .banner           (banner)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, fr, pc, ar, input logic [1:0] lv,
                               input logic [54:0] inv, input logic [9:0] inv_y,
                               input logic [2:0] es, input logic er, ew, eg,
                               input logic [3:0] ewv, input logic eb);
      vec_t v;
      v.st = st; v.fr = fr; v.pc = pc; v.ar = ar; v.lv = lv; v.inv = inv; v.inv_y = inv_y;
      v.e_state = es; v.e_run = er; v.e_wrst = ew; v.e_grst = eg; v.e_wave = ewv; v.e_banner = eb;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input int es, input int er, input int ew,
                             input int eg, input int ewv, input int eb);
      chk({name, ".state"},    int'(state),    es);
      chk({name, ".run_en"},   int'(run_en),   er);
      chk({name, ".wave_rst"}, int'(wave_rst), ew);
      chk({name, ".game_rst"}, int'(game_rst), eg);
      chk({name, ".wave"},     int'(wave),     ewv);
      chk({name, ".banner"},   int'(banner),   eb);
      $display("%s: state=%0d run_en=%0d wave_rst=%0d game_rst=%0d wave=%0d banner=%0d",
               name, state, run_en, wave_rst, game_rst, wave, banner);
   endtask

   task automatic cyc(input logic st, input logic fr, input logic pc, input logic ar);
      @(negedge clk);
      start = st; frame = fr; player_collision = pc; arst = ar;
      @(posedge clk);
      #1;
      start = 1'b0; frame = 1'b0; player_collision = 1'b0; arst = 1'b0;
   endtask

   // Idle clock then a frame pulse, so the last edge is always a frame edge.
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic apply_vec(input int i);
      lives      = vecs[i].lv;
      invaders   = vecs[i].inv;
      invaders_y = vecs[i].inv_y;
      cyc(vecs[i].st, vecs[i].fr, vecs[i].pc, vecs[i].ar);
      check_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_run, vecs[i].e_wrst,
                 vecs[i].e_grst, vecs[i].e_wave, vecs[i].e_banner);
   endtask

   initial begin
      rst = 1'b1; arst = 1'b0; start = 1'b0; frame = 1'b0; player_collision = 1'b0;
      lives = 2'd2; invaders = ALL; invaders_y = 10'd0;

      //            st fr pc ar lv    inv      y        st   run wr gr wave ban
      vecs[0]  = mk(1, 0, 0, 0, 2'd2, ALL,     10'd0,   3'd1, 0, 1, 1, 4'd1, 1);
      vecs[1]  = mk(0, 0, 0, 0, 2'd2, ALL,     10'd0,   3'd1, 0, 0, 0, 4'd1, 1);
      vecs[2]  = mk(1, 0, 0, 0, 2'd2, ALL,     10'd0,   3'd1, 0, 0, 0, 4'd1, 1);
      vecs[3]  = mk(0, 0, 1, 0, 2'd2, ALL,     10'd0,   3'd1, 0, 0, 0, 4'd1, 1);
      vecs[4]  = mk(0, 0, 0, 0, 2'd2, ALL,     10'd0,   3'd2, 1, 0, 0, 4'd1, 0);
      vecs[5]  = mk(1, 0, 0, 0, 2'd2, ALL,     10'd0,   3'd2, 1, 0, 0, 4'd1, 0);
      vecs[6]  = mk(0, 1, 0, 0, 2'd2, ALL,     10'd0,   3'd2, 1, 0, 0, 4'd1, 0);
      vecs[7]  = mk(0, 0, 1, 0, 2'd2, ALL,     10'd0,   3'd3, 0, 0, 0, 4'd1, 0);
      vecs[8]  = mk(0, 0, 1, 0, 2'd2, ALL,     10'd0,   3'd3, 0, 0, 0, 4'd1, 0);
      vecs[9]  = mk(0, 0, 0, 0, 2'd2, 55'd0,   10'd0,   3'd4, 0, 0, 0, 4'd1, 1);
      vecs[10] = mk(0, 0, 0, 0, 2'd2, ALL,     10'd319, 3'd2, 1, 0, 0, 4'd15, 0);
      vecs[11] = mk(0, 0, 1, 0, 2'd2, 55'd1,   10'd330, 3'd5, 0, 0, 0, 4'd15, 1);
      vecs[12] = mk(0, 0, 0, 1, 2'd2, ALL,     10'd0,   3'd0, 0, 0, 0, 4'd1, 1);

      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 0, 0, 0, 0, 1, 1);
      rst = 1'b0;

      // ATTRACT -> START, then start/collision ignored in START
      for (int i = 0; i <= 3; i++) apply_vec(i);
      frames(119);
      check_outs("start_119", 1, 0, 0, 0, 1, 1);
      frames(1);
      check_outs("start_120", 2, 1, 0, 0, 1, 0);

      // PLAY: start and frames ignored, then hit with lives left
      for (int i = 4; i <= 7; i++) apply_vec(i);
      frames(89);
      check_outs("hit_89", 3, 0, 0, 0, 1, 0);
      frames(1);
      check_outs("hit_90", 2, 1, 0, 0, 1, 0);

      // Hit again; lives drop to zero during the freeze
      apply_vec(8);
      lives = 2'd0;
      frames(90);
      check_outs("hit_last", 5, 0, 0, 0, 1, 1);

      // OVER lockout, including frame+start one short of the threshold
      frames(100);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_outs("over_early", 5, 0, 0, 0, 1, 1);
      frames(78);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check_outs("over_simul", 5, 0, 0, 0, 1, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_outs("over_exit", 1, 0, 1, 1, 1, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check_outs("pulse_once", 1, 0, 0, 0, 1, 1);

      // Wave clear
      lives = 2'd2;
      frames(120);
      check_outs("play2", 2, 1, 0, 0, 1, 0);
      apply_vec(9);
      invaders = ALL;
      frames(119);
      check_outs("clear_119", 4, 0, 0, 0, 1, 1);
      frames(1);
      check_outs("clear_120", 1, 0, 1, 0, 2, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check_outs("clear_after", 1, 0, 0, 0, 2, 1);

      // Advance waves up to saturation
      for (int w = 2; w <= 15; w++) begin
         frames(120);
         chk($sformatf("wave%0d.play", w), int'(state), 2);
         invaders = 55'd0;
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         invaders = ALL;
         frames(120);
         chk($sformatf("wave%0d.next", w), int'(wave), (w + 1 > 15) ? 15 : w + 1);
         $display("wave step %0d: state=%0d wave=%0d", w, state, wave);
      end
      check_outs("wave_sat", 1, 0, 1, 0, 15, 1);

      // Invasion boundary and priority over collision
      frames(120);
      apply_vec(10);
      apply_vec(11);

      // Restart from OVER, then arst in PLAY
      invaders = ALL;
      invaders_y = 10'd0;
      frames(179);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_outs("over_restart", 1, 0, 1, 1, 1, 1);
      frames(120);
      check_outs("play3", 2, 1, 0, 0, 1, 0);
      apply_vec(12);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_outs("after_arst", 1, 0, 1, 1, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
